// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: IorD mux selects, exception causes/ExcCodes,
// exception sequencer state encodings and default vector addresses.
package cpu_defs_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IORD_PC         = 2'b00,
    IORD_ALUOUT     = 2'b01,
    IORD_ALU_RESULT = 2'b10,
    IORD_EXCPT      = 2'b11
  } iord_sel_e;

  typedef enum logic [1:0] {
    CAUSE_OPCODE = 2'b00,
    CAUSE_OVF    = 2'b01,
    CAUSE_DIV0   = 2'b10,
    CAUSE_RSVD   = 2'b11
  } cause_e;

  localparam logic [4:0] EXC_CODE_OPCODE = 5'd10;
  localparam logic [4:0] EXC_CODE_OVF    = 5'd12;
  localparam logic [4:0] EXC_CODE_DIV0   = 5'd15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_ADDR    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_LOAD    = 3'd4
  } exc_state_e;

  localparam logic [XLEN-1:0] VEC_OPCODE_DEF = 32'd253;
  localparam logic [XLEN-1:0] VEC_OVF_DEF    = 32'd254;
  localparam logic [XLEN-1:0] VEC_DIV0_DEF   = 32'd255;

  // MIPS ExcCode for a cause; the reserved encoding folds onto invalid opcode.
  function automatic logic [4:0] exc_code(input cause_e c);
    case (c)
      CAUSE_OVF:  return EXC_CODE_OVF;
      CAUSE_DIV0: return EXC_CODE_DIV0;
      default:    return EXC_CODE_OPCODE;
    endcase
  endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational exception-cause priority encoder: opcode > div0 > ovf.
module exc_priority_enc
  import cpu_defs_pkg::*;
(
  input  logic       exc_opcode,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  output logic [1:0] cause_c,
  output logic       valid_c
);

  always_comb begin
    cause_c = CAUSE_OPCODE;
    valid_c = exc_opcode | exc_ovf | exc_div0;
    if (exc_opcode) begin
      cause_c = CAUSE_OPCODE;
    end else if (exc_div0) begin
      cause_c = CAUSE_DIV0;
    end else if (exc_ovf) begin
      cause_c = CAUSE_OVF;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Multicycle-CPU exception sequencer: capture cause, save EPC, fetch the
// handler byte through IorD input 3, load PC. Optional EXCPT_CAUSE_REG_EN
// adds a MIPS-style Cause register and a sticky lost-exception flag.
module exception_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int unsigned     MEM_LAT    = 1,
  parameter logic [XLEN-1:0] VEC_OPCODE = VEC_OPCODE_DEF,
  parameter logic [XLEN-1:0] VEC_OVF    = VEC_OVF_DEF,
  parameter logic [XLEN-1:0] VEC_DIV0   = VEC_DIV0_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            exc_opcode,
  input  logic            exc_ovf,
  input  logic            exc_div0,
  input  logic [XLEN-1:0] pc_cur,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] Excpt_Out,
  output logic            iord_force,
  output logic [XLEN-1:0] epc_out,
  output logic            epc_write,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_load_value,
`ifdef EXCPT_CAUSE_REG_EN
  output logic [XLEN-1:0] cause_out,
  output logic            lost_exc,
`endif
  output logic            busy
);

  exc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_c;
  logic             any_c;
  cause_e           cause_q;
  logic             capture_c, vec_load_c;
  logic             busy_d, iord_d, epc_wr_d, pc_load_d;
  logic             unused_rdata_bits;

  assign unused_rdata_bits = ^mem_rdata[23:0];

  exc_priority_enc u_prio (
    .exc_opcode (exc_opcode),
    .exc_ovf    (exc_ovf),
    .exc_div0   (exc_div0),
    .cause_c    (cause_c),
    .valid_c    (any_c)
  );

  function automatic logic [XLEN-1:0] vec_of(input cause_e c);
    case (c)
      CAUSE_OVF:  return VEC_OVF;
      CAUSE_DIV0: return VEC_DIV0;
      default:    return VEC_OPCODE;
    endcase
  endfunction

  // State and registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy       <= 1'b0;
      iord_force <= 1'b0;
      epc_write  <= 1'b0;
      pc_load    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      iord_force <= iord_d;
      epc_write  <= epc_wr_d;
      pc_load    <= pc_load_d;
    end
  end

  // Next state; control outputs decoded from the state being entered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture_c  = 1'b0;
    vec_load_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          state_d   = ST_CAPTURE;
          capture_c = 1'b1;
        end
      end
      ST_CAPTURE: begin
        state_d    = ST_ADDR;
        vec_load_c = 1'b1;
      end
      ST_ADDR: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = (MEM_LAT <= 1) ? ST_LOAD : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d    = (state_d != ST_IDLE);
    iord_d    = (state_d == ST_ADDR) || (state_d == ST_WAIT) || (state_d == ST_LOAD);
    epc_wr_d  = (state_d == ST_CAPTURE);
    pc_load_d = (state_d == ST_LOAD);
  end

  // Captured cause, EPC and the held vector address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q   <= CAUSE_OPCODE;
      epc_out   <= '0;
      Excpt_Out <= '0;
    end else begin
      if (capture_c) begin
        cause_q <= cause_e'(cause_c);
        epc_out <= pc_cur - XLEN'(4);
      end
      if (vec_load_c) begin
        Excpt_Out <= vec_of(cause_q);
      end
    end
  end

  // Handler address is the big-endian addressed byte, valid while pc_load is high.
  assign pc_load_value = pc_load ? XLEN'(mem_rdata[31:24]) : '0;

`ifdef EXCPT_CAUSE_REG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_out <= '0;
      lost_exc  <= 1'b0;
    end else begin
      if (capture_c) begin
        cause_out <= XLEN'({exc_code(cause_e'(cause_c)), 2'b00});
      end
      if (busy && any_c) begin
        lost_exc <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomized self-checking bench for exception_ctrl at MEM_LAT=1 and MEM_LAT=3,
// against a phase-count reference model (covers EXCPT_CAUSE_REG_EN when defined).
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exc_opcode, exc_ovf, exc_div0;
  logic [31:0] pc_cur, mem_rdata;

  logic [31:0] a_xout, a_epc, a_plv, b_xout, b_epc, b_plv;
  logic        a_iof, a_epw, a_pl, a_busy, b_iof, b_epw, b_pl, b_busy;
  logic [31:0] a_cause, b_cause;
  logic        a_lost, b_lost;

  int checks = 0;
  int failures = 0;

  // Reference model state, index 0 = MEM_LAT 1, index 1 = MEM_LAT 3.
  int          lat [2] = '{1, 3};
  int          ph  [2];
  logic [31:0] m_epc [2], m_vec [2], m_xout [2], m_cause [2], m_cause_nx [2];
  logic        m_lost [2];

  always #5 clk = ~clk;

  exception_ctrl #(.MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .pc_cur(pc_cur), .mem_rdata(mem_rdata),
    .Excpt_Out(a_xout), .iord_force(a_iof), .epc_out(a_epc), .epc_write(a_epw),
    .pc_load(a_pl), .pc_load_value(a_plv),
`ifdef EXCPT_CAUSE_REG_EN
    .cause_out(a_cause), .lost_exc(a_lost),
`endif
    .busy(a_busy)
  );

  exception_ctrl #(.MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .reset_n(reset_n), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .pc_cur(pc_cur), .mem_rdata(mem_rdata),
    .Excpt_Out(b_xout), .iord_force(b_iof), .epc_out(b_epc), .epc_write(b_epw),
    .pc_load(b_pl), .pc_load_value(b_plv),
`ifdef EXCPT_CAUSE_REG_EN
    .cause_out(b_cause), .lost_exc(b_lost),
`endif
    .busy(b_busy)
  );

`ifndef EXCPT_CAUSE_REG_EN
  assign a_cause = '0;
  assign b_cause = '0;
  assign a_lost  = 1'b0;
  assign b_lost  = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input logic [31:0] xo, input logic [31:0] ep,
                            input logic [31:0] plv, input logic iof, input logic epw,
                            input logic pl, input logic bs, input logic [31:0] co,
                            input logic le);
    string p;
    logic  exp_pl;
    p      = $sformatf("L%0d", lat[i]);
    exp_pl = (ph[i] == lat[i] + 2);
    check({p, " busy"},       32'(bs),  32'(ph[i] != 0));
    check({p, " epc_write"},  32'(epw), 32'(ph[i] == 1));
    check({p, " iord_force"}, 32'(iof), 32'(ph[i] >= 2));
    check({p, " pc_load"},    32'(pl),  32'(exp_pl));
    check({p, " Excpt_Out"},  xo, m_xout[i]);
    check({p, " epc_out"},    ep, m_epc[i]);
    if (exp_pl) check({p, " pc_load_value"}, plv, {24'h0, mem_rdata[31:24]});
`ifdef EXCPT_CAUSE_REG_EN
    check({p, " cause_out"}, co, m_cause[i]);
    check({p, " lost_exc"},  32'(le), 32'(m_lost[i]));
`else
    if (co !== 32'h0 || le !== 1'b0) check({p, " optional tie-off"}, co, 32'h0);
`endif
  endtask

  task automatic check_all();
    check_inst(0, a_xout, a_epc, a_plv, a_iof, a_epw, a_pl, a_busy, a_cause, a_lost);
    check_inst(1, b_xout, b_epc, b_plv, b_iof, b_epw, b_pl, b_busy, b_cause, b_lost);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; m_epc[i] = '0; m_vec[i] = '0; m_xout[i] = '0;
      m_cause[i] = '0; m_lost[i] = 1'b0;
    end
  endtask

  // One rising edge of the reference model: phase 1 = capture, 2..L+1 address
  // on the bus, L+2 = handler load; pulses seen while busy are dropped.
  task automatic model_step();
    logic any;
    any = exc_opcode | exc_ovf | exc_div0;
    for (int i = 0; i < 2; i++) begin
      if (ph[i] != 0) begin
        if (any) m_lost[i] = 1'b1;
        ph[i] = (ph[i] == lat[i] + 2) ? 0 : ph[i] + 1;
        if (ph[i] == 2) m_xout[i] = m_vec[i];
      end else if (any) begin
        ph[i]    = 1;
        m_epc[i] = pc_cur - 32'd4;
        if (exc_opcode)    begin m_vec[i] = 32'd253; m_cause[i] = 32'd10 << 2; end
        else if (exc_div0) begin m_vec[i] = 32'd255; m_cause[i] = 32'd15 << 2; end
        else               begin m_vec[i] = 32'd254; m_cause[i] = 32'd12 << 2; end
      end
    end
  endtask

  // One clock: check at the falling edge, drive, then advance the model on the rising edge.
  task automatic tick(input logic rst, input logic o, input logic v, input logic d,
                      input logic [31:0] pc, input logic [31:0] mem);
    @(negedge clk);
    check_all();
    reset_n    = rst;
    exc_opcode = o;
    exc_ovf    = v;
    exc_div0   = d;
    pc_cur     = pc;
    mem_rdata  = mem;
    if (!rst) begin
      #1;
      model_reset();
      check_all();
    end
    @(posedge clk);
    if (reset_n) model_step();
  endtask

  task automatic idle(input int n, input logic [31:0] mem);
    for (int c = 0; c < n; c++) tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678, mem);
  endtask

  initial begin
    reset_n = 1'b0; exc_opcode = 1'b0; exc_ovf = 1'b1; exc_div0 = 1'b0;
    pc_cur = 32'h40; mem_rdata = 32'hA000_0000;
    model_reset();

    // Reset held with an overflow pending, then release into a sequence.
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'hA000_0000);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'hA000_0000);
    idle(7, 32'hA000_0000);

    // Simultaneous opcode and overflow: opcode wins.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h5500_0000);
    idle(7, 32'h5500_0000);

    // Divide-by-zero at pc 0, with an extra overflow pulse mid-sequence.
    tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'hC300_00FF);
    idle(2, 32'hC300_00FF);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h888, 32'hC300_00FF);
    idle(6, 32'hC300_00FF);

    // Reset during WAIT, then a clean opcode sequence.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 32'h7700_0000);
    idle(2, 32'h7700_0000);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h7700_0000);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h7700_0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h3004, 32'h1E00_0000);
    idle(7, 32'h1E00_0000);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           $urandom, $urandom);
    end
    idle(6, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
